capture_readback: RTL and testbench

- Downstream readback engine that replaces the dummy return-data consumer.
- Walks a captured region of DDR2, issuing line reads through the read-request side of the DDR memory interface while bounding the number of reads in flight.
- Pops each returned 128-bit line and unpacks it into four 32-bit sample packets.
- Streams the packets over a valid/ready interface toward the host link.

---
 rtl/capture_readback.sv | 232 +++++++++++++++++++++++
 tb/tb_capture_readback.sv | 539 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_readback.sv
// -----------------------------------------------------------------------------
// capture_readback
//
// Readback engine for a captured DDR2 region. It issues line reads through the
// read-request side of the DDR memory interface, keeps at most MAX_OUTSTANDING
// reads in flight, pops each returned 128-bit line into a one-line buffer, and
// streams the line out as four 32-bit packets on a valid/ready interface.
//
// Ports
//   clk, resetn          SoC clock, asynchronous active-low reset
//   start                one-cycle pulse, begins a readback (ignored while busy)
//   abort                level, stop issuing and drain reads in flight
//   base_adx, num_lines  first line address / line count, sampled on start
//   busy, done           run indication / one-cycle completion pulse
//   read_req, rd_adx     read command and its address
//   read_allowed         interface accepts read_req this cycle
//   has_return_data      return line and address valid (first-word-fall-through)
//   get_return_data      pops the current return line
//   rd_data_return       returned 128-bit line
//   rd_adx_return        address of the returned line
//   pkt_data, pkt_valid  packet stream toward the host link
//   pkt_ready            sink accepts the packet
//   pkt_last             final packet of the readback
//   adx_error            sticky: a returned address differed from the expected
// -----------------------------------------------------------------------------
module capture_readback #(
    parameter int unsigned ADX_STEP        = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         abort,
    input  logic [26:0]  base_adx,
    input  logic [23:0]  num_lines,
    output logic         busy,
    output logic         done,
    output logic         read_req,
    output logic [26:0]  rd_adx,
    input  logic         read_allowed,
    input  logic         has_return_data,
    output logic         get_return_data,
    input  logic [127:0] rd_data_return,
    input  logic [26:0]  rd_adx_return,
    output logic [31:0]  pkt_data,
    output logic         pkt_valid,
    input  logic         pkt_ready,
    output logic         pkt_last,
    output logic         adx_error
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [26:0] STEP    = 27'(ADX_STEP);
    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

    logic [1:0]   state_q,       state_d;
    logic [23:0]  num_lines_q,   num_lines_d;
    logic [23:0]  issued_q,      issued_d;
    logic [23:0]  popped_q,      popped_d;
    logic [3:0]   outstanding_q, outstanding_d;
    logic [26:0]  rd_adx_q,      rd_adx_d;
    logic [26:0]  exp_adx_q,     exp_adx_d;
    logic [127:0] line_q,        line_d;
    logic         line_valid_q,  line_valid_d;
    logic [1:0]   word_q,        word_d;
    logic         adx_error_q,   adx_error_d;

    logic in_run;
    logic in_drain;
    logic issue;
    logic pop;
    logic accept;
    logic all_done;

    assign in_run   = (state_q == S_RUN);
    assign in_drain = (state_q == S_DRAIN);

    assign read_req = in_run && !abort && (issued_q < num_lines_q)
                      && (outstanding_q < MAX_OUT);
    assign issue    = read_req && read_allowed;

    // Pops only while a transfer is active, so a stray return in IDLE cannot
    // disturb the outstanding count. In DRAIN every return is discarded.
    assign get_return_data = has_return_data && ((in_run && !line_valid_q) || in_drain);
    assign pop             = get_return_data;

    assign pkt_valid = in_run && line_valid_q;
    assign accept    = pkt_valid && pkt_ready;

    // Only one line is ever buffered, so the buffered line is the most recently
    // popped one; it is the final line when every line has been popped.
    assign pkt_last = pkt_valid && (word_q == 2'd3) && (popped_q == num_lines_q);

    assign all_done = (issued_q == num_lines_q) && (popped_q == num_lines_q) && !line_valid_q;

    assign busy      = in_run || in_drain;
    assign done      = (state_q == S_FIN);
    assign rd_adx    = rd_adx_q;
    assign adx_error = adx_error_q;

    always_comb begin
        pkt_data = line_q[31:0];
        case (word_q)
            2'd0:    pkt_data = line_q[31:0];
            2'd1:    pkt_data = line_q[63:32];
            2'd2:    pkt_data = line_q[95:64];
            default: pkt_data = line_q[127:96];
        endcase
    end

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path
        // leaves one unassigned; this is what keeps the block latch-free.
        state_d       = state_q;
        num_lines_d   = num_lines_q;
        issued_d      = issued_q;
        popped_d      = popped_q;
        outstanding_d = outstanding_q;
        rd_adx_d      = rd_adx_q;
        exp_adx_d     = exp_adx_q;
        line_d        = line_q;
        line_valid_d  = line_valid_q;
        word_d        = word_q;
        adx_error_d   = adx_error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d       = S_RUN;
                    num_lines_d   = num_lines;
                    rd_adx_d      = base_adx;
                    exp_adx_d     = base_adx;
                    issued_d      = '0;
                    popped_d      = '0;
                    outstanding_d = '0;
                    line_valid_d  = 1'b0;
                    word_d        = '0;
                    adx_error_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_DRAIN;
                end else if (all_done) begin
                    state_d = S_FIN;
                end
            end
            S_DRAIN: begin
                if (outstanding_q == 4'd0) begin
                    state_d = S_FIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // issue and pop are already qualified by state, so the datapath below
        // never fires in IDLE and cannot collide with the start assignments.
        if (issue) begin
            rd_adx_d = rd_adx_q + STEP;
            issued_d = issued_q + 24'd1;
        end

        if (pop) begin
            exp_adx_d = exp_adx_q + STEP;
            popped_d  = popped_q + 24'd1;
            if (rd_adx_return != exp_adx_q) begin
                adx_error_d = 1'b1;
            end
        end

        case ({issue, pop})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase

        // A pop requires an empty buffer, so it never coincides with an accept.
        if (pop && in_run) begin
            line_d       = rd_data_return;
            line_valid_d = 1'b1;
            word_d       = '0;
        end else if (accept) begin
            word_d = word_q + 2'd1;
            if (word_q == 2'd3) begin
                line_valid_d = 1'b0;
            end
        end

        if (in_drain) begin
            line_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            num_lines_q   <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            outstanding_q <= '0;
            rd_adx_q      <= '0;
            exp_adx_q     <= '0;
            // NOTE: the line buffer is a plain register, not a RAM, so it is
            // cleared with everything else and pkt_data reads 0 out of reset.
            line_q        <= '0;
            line_valid_q  <= 1'b0;
            word_q        <= '0;
            adx_error_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the values
            // computed from the same pre-edge state.
            state_q       <= state_d;
            num_lines_q   <= num_lines_d;
            issued_q      <= issued_d;
            popped_q      <= popped_d;
            outstanding_q <= outstanding_d;
            rd_adx_q      <= rd_adx_d;
            exp_adx_q     <= exp_adx_d;
            line_q        <= line_d;
            line_valid_q  <= line_valid_d;
            word_q        <= word_d;
            adx_error_q   <= adx_error_d;
        end
    end

endmodule

// File: tb/tb_capture_readback.sv
// -----------------------------------------------------------------------------
// tb_capture_readback
//
// Drives capture_readback with a FIFO-style DDR return model and a packet sink.
// Inputs change on the falling edge; outputs are sampled 1 ns later, and the
// transactions seen there are committed to the model after the rising edge.
// Expected packet streams and read addresses come from the line-by-line
// description: line i lives at base + i*ADX_STEP (mod 2^27) and carries four
// words derived from that address.
// -----------------------------------------------------------------------------
module tb_capture_readback;

    localparam int STEP = 8;
    localparam int MAXO = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         abort;
    logic [26:0]  base_adx;
    logic [23:0]  num_lines;
    logic         busy;
    logic         done;
    logic         read_req;
    logic [26:0]  rd_adx;
    logic         read_allowed;
    logic         has_return_data;
    logic         get_return_data;
    logic [127:0] rd_data_return;
    logic [26:0]  rd_adx_return;
    logic [31:0]  pkt_data;
    logic         pkt_valid;
    logic         pkt_ready;
    logic         pkt_last;
    logic         adx_error;

    capture_readback #(.ADX_STEP(STEP), .MAX_OUTSTANDING(MAXO)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start),
        .abort           (abort),
        .base_adx        (base_adx),
        .num_lines       (num_lines),
        .busy            (busy),
        .done            (done),
        .read_req        (read_req),
        .rd_adx          (rd_adx),
        .read_allowed    (read_allowed),
        .has_return_data (has_return_data),
        .get_return_data (get_return_data),
        .rd_data_return  (rd_data_return),
        .rd_adx_return   (rd_adx_return),
        .pkt_data        (pkt_data),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .pkt_last        (pkt_last),
        .adx_error       (adx_error)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Environment controls
    int   ret_mode;     // 0: return whenever available, 1: random gaps, 2: withhold
    int   rdy_mode;     // 0: always ready, 1: toggle each cycle, 2: random
    int   ret_budget;   // returns still permitted, -1 = unlimited
    int   corrupt_idx;  // pop index whose return address is corrupted, -1 = none
    bit   ra_rand;
    bit   ra_off;
    bit   tog;
    logic [31:0] salt;

    // Memory model and per-run logs
    logic [26:0] pending[$];
    logic [26:0] iss_log[$];
    logic [31:0] pkt_log[$];
    bit          last_log[$];
    logic [31:0] exp_data[$];
    bit          exp_last[$];

    int pops, done_cnt, busy_cnt, stall_viol, pop_viol, max_out, cyc, done_cyc, start_cyc;
    int req_after_abort, pops_after_abort, pkts_after_abort;
    bit abort_prev, prev_stall, prev_last;
    logic [31:0] prev_data;

    function automatic logic [31:0] word_of(logic [26:0] a, int j);
        logic [1:0] jj;
        jj = 2'(j);
        return {jj, 3'b101, a} ^ salt;
    endfunction

    function automatic logic [26:0] line_adx(logic [26:0] b, int i);
        longint s;
        s = longint'(b) + longint'(i) * STEP;
        return 27'(s % (longint'(1) << 27));
    endfunction

    task automatic build_model(input logic [26:0] b, input int n);
        logic [26:0] a;
        exp_data.delete();
        exp_last.delete();
        for (int i = 0; i < n; i++) begin
            a = line_adx(b, i);
            for (int j = 0; j < 4; j++) begin
                exp_data.push_back(word_of(a, j));
                exp_last.push_back(i == n - 1 && j == 3);
            end
        end
    endtask

    task automatic clear_logs();
        pending.delete();
        iss_log.delete();
        pkt_log.delete();
        last_log.delete();
        pops = 0; done_cnt = 0; busy_cnt = 0; stall_viol = 0; pop_viol = 0; max_out = 0;
        done_cyc = -1;
        req_after_abort = 0; pops_after_abort = 0; pkts_after_abort = 0;
        abort_prev = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
        ret_budget = -1; corrupt_idx = -1;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, commit
    // the observed transactions after the rising edge.
    task automatic cycle();
        bit          iss, pp, acc, lst;
        logic [26:0] adx_now;
        logic [31:0] dat_now;
        read_allowed = ra_off ? 1'b0 : (ra_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        if (pending.size() > 0 && ret_budget != 0 &&
            (ret_mode == 0 || (ret_mode == 1 && $urandom_range(0, 2) != 0))) begin
            has_return_data = 1'b1;
            rd_adx_return   = (pops == corrupt_idx) ? (pending[0] ^ 27'h1) : pending[0];
            rd_data_return  = {word_of(pending[0], 3), word_of(pending[0], 2),
                               word_of(pending[0], 1), word_of(pending[0], 0)};
        end else begin
            has_return_data = 1'b0;
            rd_adx_return   = 27'($urandom);
            rd_data_return  = {$urandom, $urandom, $urandom, $urandom};
        end
        tog = ~tog;
        pkt_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : 1'($urandom_range(0, 1));
        #1;
        iss     = read_req && read_allowed;
        pp      = get_return_data && has_return_data;
        acc     = pkt_valid && pkt_ready;
        adx_now = rd_adx;
        dat_now = pkt_data;
        lst     = pkt_last;
        if (prev_stall && !abort && !abort_prev &&
            (!pkt_valid || pkt_data !== prev_data || pkt_last !== prev_last)) stall_viol++;
        prev_stall = pkt_valid && !pkt_ready;
        prev_data  = pkt_data;
        prev_last  = pkt_last;
        if (pp && !abort && !abort_prev && pops * 4 != pkt_log.size()) pop_viol++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (busy) busy_cnt++;
        if ((abort || abort_prev) && read_req) req_after_abort++;
        if ((abort || abort_prev) && pp) pops_after_abort++;
        if (abort_prev && pkt_valid) pkts_after_abort++;
        abort_prev = abort_prev | abort;
        @(negedge clk);
        cyc++;
        if (iss) begin pending.push_back(adx_now); iss_log.push_back(adx_now); end
        if (pp) begin void'(pending.pop_front()); pops++; if (ret_budget > 0) ret_budget--; end
        if (acc) begin pkt_log.push_back(dat_now); last_log.push_back(lst); end
        if (iss_log.size() - pops > max_out) max_out = iss_log.size() - pops;
    endtask

    task automatic start_run(input logic [26:0] b, input logic [23:0] n);
        clear_logs();
        build_model(b, int'(n));
        base_adx  = b;
        num_lines = n;
        start     = 1'b1;
        start_cyc = cyc;
        cycle();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
        ok = (done_cnt > 0);
        repeat (3) cycle();
    endtask

    // ---------------------------------------------------------------- tests

    task automatic test_reset();
        has_return_data = 1'b0;
        #1;
        vectors++;
        if ({busy, done, read_req, get_return_data, pkt_valid, pkt_last, adx_error} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, want 0000000",
                     {busy, done, read_req, get_return_data, pkt_valid, pkt_last, adx_error});
        end
        vectors++;
        if (rd_adx !== 27'h0 || pkt_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got rd_adx=%h pkt_data=%h, want 0/0", rd_adx, pkt_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || read_req !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b req=%b done=%b, want 0/0/0", busy, read_req, done);
        end
    endtask

    task automatic test_basic();
        bit ok;
        ret_mode = 0; rdy_mode = 0; ra_rand = 0; ra_off = 0;
        start_run(27'h100, 24'd3);
        wait_done(200, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL basic_done: got no done, want done pulse"); end
        vectors++;
        if (iss_log.size() != 3) begin
            miscompares++; $display("FAIL basic_reads: got %0d, want 3", iss_log.size());
        end
        for (int i = 0; i < iss_log.size() && i < 3; i++) begin
            vectors++;
            if (iss_log[i] !== line_adx(27'h100, i)) begin
                miscompares++;
                $display("FAIL basic_adx[%0d]: got %h, want %h", i, iss_log[i], line_adx(27'h100, i));
            end
        end
        vectors++;
        if (pkt_log.size() != exp_data.size()) begin
            miscompares++; $display("FAIL basic_count: got %0d, want %0d", pkt_log.size(), exp_data.size());
        end
        for (int i = 0; i < pkt_log.size() && i < exp_data.size(); i++) begin
            vectors++;
            if (pkt_log[i] !== exp_data[i] || last_log[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL basic_pkt[%0d]: got %h/%0b, want %h/%0b",
                         i, pkt_log[i], last_log[i], exp_data[i], exp_last[i]);
            end
        end
        vectors++;
        if (done_cnt != 1 || busy !== 1'b0 || adx_error !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_end: got done_cnt=%0d busy=%b err=%b, want 1/0/0", done_cnt, busy, adx_error);
        end
    endtask

    task automatic test_withheld();
        bit ok;
        ret_mode = 2; rdy_mode = 0; ra_rand = 0; ra_off = 0;
        start_run(27'h2000, 24'd10);
        repeat (20) cycle();
        vectors++;
        if (iss_log.size() != MAXO || read_req !== 1'b0) begin
            miscompares++;
            $display("FAIL withheld_cap: got reads=%0d req=%b, want %0d/0", iss_log.size(), read_req, MAXO);
        end
        ret_mode = 0; ret_budget = 1;
        repeat (12) cycle();
        vectors++;
        if (pops != 1 || iss_log.size() != MAXO + 1) begin
            miscompares++;
            $display("FAIL withheld_resume: got pops=%0d reads=%0d, want 1/%0d", pops, iss_log.size(), MAXO + 1);
        end
        ret_budget = -1;
        wait_done(400, ok);
        vectors++;
        if (!ok || done_cnt != 1 || max_out != MAXO) begin
            miscompares++;
            $display("FAIL withheld_end: got ok=%0b done_cnt=%0d max_out=%0d, want 1/1/%0d", ok, done_cnt, max_out, MAXO);
        end
        vectors++;
        if (pkt_log.size() != exp_data.size()) begin
            miscompares++; $display("FAIL withheld_count: got %0d, want %0d", pkt_log.size(), exp_data.size());
        end
        for (int i = 0; i < pkt_log.size() && i < exp_data.size(); i++) begin
            vectors++;
            if (pkt_log[i] !== exp_data[i] || last_log[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL withheld_pkt[%0d]: got %h/%0b, want %h/%0b",
                         i, pkt_log[i], last_log[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [26:0] b;
        ret_mode = 1; rdy_mode = 1; ra_rand = 1; ra_off = 0;
        b = 27'($urandom);
        start_run(b, 24'd6);
        wait_done(800, ok);
        vectors++;
        if (!ok || stall_viol != 0 || pop_viol != 0 || max_out > MAXO) begin
            miscompares++;
            $display("FAIL stall_rules: got ok=%0b stall=%0d pop=%0d max_out=%0d, want 1/0/0/<=%0d",
                     ok, stall_viol, pop_viol, max_out, MAXO);
        end
        vectors++;
        if (pkt_log.size() != exp_data.size()) begin
            miscompares++; $display("FAIL stall_count: got %0d, want %0d", pkt_log.size(), exp_data.size());
        end
        for (int i = 0; i < pkt_log.size() && i < exp_data.size(); i++) begin
            vectors++;
            if (pkt_log[i] !== exp_data[i] || last_log[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL stall_pkt[%0d]: got %h/%0b, want %h/%0b",
                         i, pkt_log[i], last_log[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int pre_pkts;
        ret_mode = 2; rdy_mode = 0; ra_rand = 0; ra_off = 0;
        start_run(27'h4000, 24'd8);
        repeat (10) cycle();
        ra_off = 1; ret_mode = 0; ret_budget = 2;
        repeat (20) cycle();
        ra_off = 0;
        for (int i = 0; i < 20 && iss_log.size() < 5; i++) cycle();
        vectors++;
        if (iss_log.size() != 5 || pops != 2 || pkt_log.size() != 8) begin
            miscompares++;
            $display("FAIL abort_setup: got reads=%0d pops=%0d pkts=%0d, want 5/2/8",
                     iss_log.size(), pops, pkt_log.size());
        end
        pre_pkts   = pkt_log.size();
        abort      = 1'b1;
        ret_budget = -1;
        wait_done(100, ok);
        abort = 1'b0;
        vectors++;
        if (!ok || done_cnt != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_done: got ok=%0b done_cnt=%0d busy=%b, want 1/1/0", ok, done_cnt, busy);
        end
        vectors++;
        if (req_after_abort != 0 || iss_log.size() != 5) begin
            miscompares++;
            $display("FAIL abort_noreq: got req=%0d reads=%0d, want 0/5", req_after_abort, iss_log.size());
        end
        vectors++;
        if (pops_after_abort != 3) begin
            miscompares++; $display("FAIL abort_drain: got %0d pops, want 3", pops_after_abort);
        end
        vectors++;
        if (pkts_after_abort != 0 || pkt_log.size() != pre_pkts) begin
            miscompares++;
            $display("FAIL abort_nopkt: got valid=%0d pkts=%0d, want 0/%0d", pkts_after_abort, pkt_log.size(), pre_pkts);
        end
        for (int i = 0; i < pkt_log.size() && i < 8; i++) begin
            vectors++;
            if (pkt_log[i] !== exp_data[i]) begin
                miscompares++; $display("FAIL abort_pkt[%0d]: got %h, want %h", i, pkt_log[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        ret_mode = 0; rdy_mode = 0; ra_rand = 0; ra_off = 0;
        start_run(27'h7FFFFF8, 24'd2);
        wait_done(200, ok);
        vectors++;
        if (!ok || iss_log.size() != 2) begin
            miscompares++; $display("FAIL wrap_reads: got ok=%0b reads=%0d, want 1/2", ok, iss_log.size());
        end else begin
            vectors++;
            if (iss_log[1] !== 27'h0) begin
                miscompares++; $display("FAIL wrap_adx: got %h, want 0000000", iss_log[1]);
            end
        end
        vectors++;
        if (pkt_log.size() != 8 || adx_error !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_end: got pkts=%0d err=%b, want 8/0", pkt_log.size(), adx_error);
        end
        for (int i = 0; i < pkt_log.size() && i < exp_data.size(); i++) begin
            vectors++;
            if (pkt_log[i] !== exp_data[i] || last_log[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL wrap_pkt[%0d]: got %h/%0b, want %h/%0b",
                         i, pkt_log[i], last_log[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_adx_error();
        bit ok;
        logic [26:0] b;
        ret_mode = 1; rdy_mode = 2; ra_rand = 1; ra_off = 0;
        b = 27'($urandom);
        start_run(b, 24'd4);
        corrupt_idx = 1;
        wait_done(600, ok);
        vectors++;
        if (!ok || adx_error !== 1'b1) begin
            miscompares++; $display("FAIL adxerr_set: got ok=%0b err=%b, want 1/1", ok, adx_error);
        end
        vectors++;
        if (pkt_log.size() != 16) begin
            miscompares++; $display("FAIL adxerr_count: got %0d, want 16", pkt_log.size());
        end
        for (int i = 0; i < pkt_log.size() && i < exp_data.size(); i++) begin
            vectors++;
            if (pkt_log[i] !== exp_data[i] || last_log[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL adxerr_pkt[%0d]: got %h/%0b, want %h/%0b",
                         i, pkt_log[i], last_log[i], exp_data[i], exp_last[i]);
            end
        end
        corrupt_idx = -1;
        repeat (5) cycle();
        vectors++;
        if (adx_error !== 1'b1) begin
            miscompares++; $display("FAIL adxerr_sticky: got %b, want 1", adx_error);
        end
        // Zero-line run: clears the flag and completes without any reads.
        ret_mode = 0; rdy_mode = 0; ra_rand = 0;
        start_run(27'h55, 24'd0);
        vectors++;
        if (adx_error !== 1'b0) begin
            miscompares++; $display("FAIL adxerr_clear: got %b, want 0", adx_error);
        end
        wait_done(20, ok);
        vectors++;
        if (!ok || done_cyc != start_cyc + 2 || busy_cnt != 1) begin
            miscompares++;
            $display("FAIL zero_timing: got done_at=%0d busy_cycles=%0d, want %0d/1",
                     done_cyc - start_cyc, busy_cnt, 2);
        end
        vectors++;
        if (iss_log.size() != 0 || pkt_log.size() != 0 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL zero_idle: got reads=%0d pkts=%0d dones=%0d, want 0/0/1",
                     iss_log.size(), pkt_log.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        ret_mode = 0; rdy_mode = 0; ra_rand = 0; ra_off = 0;
        start_run(27'h800, 24'd6);
        repeat (6) cycle();
        has_return_data = 1'b0;
        resetn = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || read_req !== 1'b0 || pkt_valid !== 1'b0 || done !== 1'b0 || rd_adx !== 27'h0) begin
            miscompares++;
            $display("FAIL midreset: got busy=%b req=%b valid=%b done=%b adx=%h, want all 0",
                     busy, read_req, pkt_valid, done, rd_adx);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        clear_logs();
        repeat (8) cycle();
        vectors++;
        if (done_cnt != 0 || iss_log.size() != 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got dones=%0d reads=%0d, want 0/0", done_cnt, iss_log.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [26:0] b;
        int n;
        for (int r = 0; r < 6; r++) begin
            ret_mode = 1; rdy_mode = 2; ra_rand = 1; ra_off = 0;
            salt = $urandom;
            b = (r % 2 == 0) ? 27'($urandom) : 27'h7FFFFF8 - 27'(8 * $urandom_range(0, 4));
            n = $urandom_range(1, 12);
            start_run(b, 24'(n));
            wait_done(2000, ok);
            vectors++;
            if (!ok || done_cnt != 1 || adx_error !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_end: got ok=%0b dones=%0d err=%b busy=%b, want 1/1/0/0",
                         r, ok, done_cnt, adx_error, busy);
            end
            vectors++;
            if (stall_viol != 0 || pop_viol != 0 || max_out > MAXO) begin
                miscompares++;
                $display("FAIL rand%0d_rules: got stall=%0d pop=%0d max_out=%0d, want 0/0/<=%0d",
                         r, stall_viol, pop_viol, max_out, MAXO);
            end
            vectors++;
            if (iss_log.size() != n || pkt_log.size() != exp_data.size()) begin
                miscompares++;
                $display("FAIL rand%0d_count: got reads=%0d pkts=%0d, want %0d/%0d",
                         r, iss_log.size(), pkt_log.size(), n, exp_data.size());
            end
            for (int i = 0; i < iss_log.size() && i < n; i++) begin
                vectors++;
                if (iss_log[i] !== line_adx(b, i)) begin
                    miscompares++;
                    $display("FAIL rand%0d_adx[%0d]: got %h, want %h", r, i, iss_log[i], line_adx(b, i));
                end
            end
            for (int i = 0; i < pkt_log.size() && i < exp_data.size(); i++) begin
                vectors++;
                if (pkt_log[i] !== exp_data[i] || last_log[i] !== exp_last[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_pkt[%0d]: got %h/%0b, want %h/%0b",
                             r, i, pkt_log[i], last_log[i], exp_data[i], exp_last[i]);
                end
            end
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0;
        base_adx = '0; num_lines = '0;
        read_allowed = 1'b0; has_return_data = 1'b0; pkt_ready = 1'b0;
        rd_data_return = '0; rd_adx_return = '0;
        tog = 1'b0; ra_off = 1'b0; ra_rand = 1'b0; ret_mode = 0; rdy_mode = 0;
        cyc = 0; salt = $urandom;
        clear_logs();
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_withheld();
        test_stall();
        test_abort();
        test_wrap();
        test_adx_error();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
